alu_multicycle: RTL

//   Execute-stage ALU, directly downstream of the ALU control decoder. Consumes the
//   3-bit ALU control code and two operands, and returns a registered result plus a

---
 rtl/alu_multicycle.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLT, iterative shift-add MUL
// behind a valid/ready handshake. Registered data_o/zero_o with a valid_o pulse.
// Optional build macro: ALU_MUL_EARLY_EXIT_EN -- MUL also finishes once the
// remaining multiplier bits above the current one are all zero.
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       ALUCtrl_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o,
   output logic             valid_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b111;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             zero_q, zero_d;
   logic             valid_q, valid_d;

   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] pp;
   logic [WIDTH-1:0] acc_sum;
   logic             accept;
   logic             mul_done;
   logic             slt;

   assign ready_o = (state_q == IDLE);
   assign accept  = valid_i && ready_o;
   assign data_o  = data_q;
   assign zero_o  = zero_q;
   assign valid_o = valid_q;

   // Single-cycle result for the non-MUL codes; undefined codes give zero.
   always_comb begin
      alu_res = '0;
      slt     = ($signed(data1_i) < $signed(data2_i));
      case (ALUCtrl_i)
         OP_AND:  alu_res = data1_i & data2_i;
         OP_OR:   alu_res = data1_i | data2_i;
         OP_ADD:  alu_res = data1_i + data2_i;
         OP_SUB:  alu_res = data1_i - data2_i;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
         default: alu_res = '0;
      endcase
   end

   // One shift-add step: partial product and the finish condition.
   always_comb begin
      pp      = mplier_q[0] ? mcand_q : '0;
      acc_sum = acc_q + pp;
`ifdef ALU_MUL_EARLY_EXIT_EN
      mul_done = (cnt_q == CW'(1)) || (mplier_q[WIDTH-1:1] == '0);
`else
      mul_done = (cnt_q == CW'(1));
`endif
   end

   // Next-state and datapath updates; outputs hold unless a result is written.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      zero_d   = zero_q;
      valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (ALUCtrl_i == OP_MUL) begin
                  mcand_d  = data1_i;
                  mplier_d = data2_i;
                  acc_d    = '0;
                  cnt_d    = CW'(WIDTH);
                  state_d  = MUL;
               end else begin
                  data_d  = alu_res;
                  zero_d  = (alu_res == '0);
                  valid_d = 1'b1;
               end
            end
         end
         MUL: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (mul_done) begin
               data_d  = acc_sum;
               zero_d  = (acc_sum == '0);
               valid_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any MUL in flight.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         zero_q   <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         zero_q   <= zero_d;
         valid_q  <= valid_d;
      end
   end

endmodule
